// File: rtl/pic_pkg.sv
// pic_pkg: shared constants and types for the programmable interrupt controller.
//   - command words written to the command port
//   - reset defaults of the delivery outputs
//   - read-select encoding and a small command-decode helper
package pic_pkg;

    // Command words accepted on the command port
    localparam logic [7:0] EOI_NS = 8'h20;   // non-specific EOI
    localparam logic [7:0] EOI_SP = 8'h60;   // specific EOI, low 3 bits select the line
    localparam logic [7:0] RD_IRR = 8'h0A;   // command-port reads return IRR
    localparam logic [7:0] RD_ISR = 8'h0B;   // command-port reads return ISR

    // Reset defaults of the registered outputs
    localparam logic       INTR_RESET   = 1'b0;
    localparam logic [7:0] INTN_RESET   = 8'h00;
    localparam logic [7:0] PORT_I_RESET = 8'h00;

    // Which request register the command port returns on a read
    typedef enum logic {
        RDSEL_IRR = 1'b0,
        RDSEL_ISR = 1'b1
    } rdsel_t;

    // True for any command in the specific-EOI group (8'h60..8'h67)
    function automatic logic is_eoi_sp(input logic [7:0] cmd);
        return (cmd[7:3] == EOI_SP[7:3]);
    endfunction

endpackage

// File: rtl/pic_prio.sv
// pic_prio: lowest-index-first priority encoder.
//   req   : request vector, bit 0 has the highest priority
//   idx   : index of the lowest set bit (0 when nothing is set)
//   valid : at least one bit of req is set
module pic_prio #(
    parameter int N_IRQ = 8
) (
    input  logic [N_IRQ-1:0] req,
    output logic [2:0]       idx,
    output logic             valid
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        idx   = 3'd0;
        valid = 1'b0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = 3'(i);
                valid = 1'b1;
            end else begin
                idx   = idx;
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/pic_ctrl.sv
// pic_ctrl: programmable interrupt controller.
//   Latches rising edges of the request lines into IRR, masks them with IMR,
//   picks the lowest-index candidate and delivers it to the core by toggling
//   intr and presenting the vector on intn. In-service lines are tracked in
//   ISR and retired by EOI commands written to the command port.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   irq          : request lines, rising edge = request, line 0 highest
//   port_a/w/r/o : I/O address, write strobe, read strobe, write data
//   port_i       : registered read data (holds for unmapped reads)
//   intr, intn   : delivery toggle and vector of the last delivery
//   isr_busy     : OR of the ISR bits
module pic_ctrl
    import pic_pkg::*;
#(
    parameter int          N_IRQ     = 8,
    parameter logic [7:0]  VEC_BASE  = 8'd8,
    parameter logic [15:0] CMD_PORT  = 16'h0020,
    parameter logic [15:0] DATA_PORT = 16'h0021,
    parameter logic [7:0]  IMR_RESET = 8'h00,
    parameter int          NESTED    = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic [15:0]      port_a,
    input  logic             port_w,
    input  logic             port_r,
    input  logic [7:0]       port_o,
    output logic [7:0]       port_i,
    output logic             intr,
    output logic [7:0]       intn,
    output logic             isr_busy
);

    logic [N_IRQ-1:0] irq_d_r;
    logic [N_IRQ-1:0] irr_r;
    logic [N_IRQ-1:0] isr_r;
    logic [N_IRQ-1:0] imr_r;
    rdsel_t           rdsel_r;

    logic [N_IRQ-1:0] edge_s;
    logic [N_IRQ-1:0] cand_s;
    logic [N_IRQ-1:0] dlv_mask_s;
    logic [N_IRQ-1:0] eoi_mask_s;
    logic [N_IRQ-1:0] irr_next_s;
    logic [N_IRQ-1:0] isr_next_s;
    logic [2:0]       cand_idx_s;
    logic             cand_vld_s;
    logic [2:0]       isr_idx_s;
    logic             isr_vld_s;
    logic             blocked_s;
    logic             deliver_s;
    logic             cmd_wr_s;
    logic             data_wr_s;
    logic             cmd_rd_s;
    logic             data_rd_s;
    logic [7:0]       irr8_s;
    logic [7:0]       isr8_s;
    logic [7:0]       imr8_s;

    assign edge_s    = irq & ~irq_d_r;
    assign cand_s    = irr_r & ~imr_r;
    assign cmd_wr_s  = port_w && (port_a == CMD_PORT);
    assign data_wr_s = port_w && (port_a == DATA_PORT);
    assign cmd_rd_s  = port_r && (port_a == CMD_PORT);
    assign data_rd_s = port_r && (port_a == DATA_PORT);
    assign isr_busy  = |isr_r;

    pic_prio #(.N_IRQ(N_IRQ)) u_prio_cand (
        .req   (cand_s),
        .idx   (cand_idx_s),
        .valid (cand_vld_s)
    );

    // Lowest set ISR bit: target of a non-specific EOI and the nesting limit
    pic_prio #(.N_IRQ(N_IRQ)) u_prio_isr (
        .req   (isr_r),
        .idx   (isr_idx_s),
        .valid (isr_vld_s)
    );

    // Delivery gate: either any in-service line blocks, or only equal/higher ones
    always_comb begin
        blocked_s = 1'b0;
        if (NESTED == 0) begin
            blocked_s = |isr_r;
        end else begin
            blocked_s = isr_vld_s && (isr_idx_s <= cand_idx_s);
        end
        deliver_s = cand_vld_s && !blocked_s;
    end

    // One-hot of the line delivered this cycle
    always_comb begin
        dlv_mask_s = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            dlv_mask_s[i] = deliver_s && (cand_idx_s == 3'(i));
        end
    end

    // ISR bits retired by an EOI command; lines beyond N_IRQ never match
    always_comb begin
        eoi_mask_s = '0;
        if (cmd_wr_s) begin
            if (port_o == EOI_NS) begin
                for (int i = 0; i < N_IRQ; i++) begin
                    eoi_mask_s[i] = isr_vld_s && (isr_idx_s == 3'(i));
                end
            end else if (is_eoi_sp(port_o)) begin
                for (int i = 0; i < N_IRQ; i++) begin
                    eoi_mask_s[i] = (port_o[2:0] == 3'(i));
                end
            end else begin
                eoi_mask_s = '0;
            end
        end else begin
            eoi_mask_s = '0;
        end
    end

    // Next IRR/ISR: a new edge beats delivery, a delivery beats an EOI
    always_comb begin
        irr_next_s = (irr_r & ~dlv_mask_s) | edge_s;
        isr_next_s = (isr_r & ~eoi_mask_s) | dlv_mask_s;
    end

    // Zero-extend the request registers to the 8-bit read bus
    always_comb begin
        irr8_s = 8'h00;
        isr8_s = 8'h00;
        imr8_s = 8'h00;
        irr8_s[N_IRQ-1:0] = irr_r;
        isr8_s[N_IRQ-1:0] = isr_r;
        imr8_s[N_IRQ-1:0] = imr_r;
    end

    // Edge history and request/in-service state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_d_r <= '0;
            irr_r   <= '0;
            isr_r   <= '0;
        end else begin
            irq_d_r <= irq;
            irr_r   <= irr_next_s;
            isr_r   <= isr_next_s;
        end
    end

    // Programmable registers: mask and command-port read select
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            imr_r   <= IMR_RESET[N_IRQ-1:0];
            rdsel_r <= RDSEL_IRR;
        end else begin
            if (data_wr_s) begin
                imr_r <= port_o[N_IRQ-1:0];
            end else begin
                imr_r <= imr_r;
            end
            if (cmd_wr_s) begin
                case (port_o)
                    RD_IRR:  rdsel_r <= RDSEL_IRR;
                    RD_ISR:  rdsel_r <= RDSEL_ISR;
                    default: rdsel_r <= rdsel_r;
                endcase
            end else begin
                rdsel_r <= rdsel_r;
            end
        end
    end

    // Delivery handshake toward the core
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            intr <= INTR_RESET;
            intn <= INTN_RESET;
        end else if (deliver_s) begin
            intr <= ~intr;
            intn <= VEC_BASE + {5'd0, cand_idx_s};
        end else begin
            intr <= intr;
            intn <= intn;
        end
    end

    // Read data; reads sample pre-write register values, unmapped reads hold
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            port_i <= PORT_I_RESET;
        end else if (cmd_rd_s) begin
            port_i <= (rdsel_r == RDSEL_ISR) ? isr8_s : irr8_s;
        end else if (data_rd_s) begin
            port_i <= imr8_s;
        end else begin
            port_i <= port_i;
        end
    end

endmodule

// File: tb/tb_pic_ctrl.sv
// tb_pic_ctrl: directed, table-driven bench for pic_ctrl.
// Two instances share the stimulus: dut0 without nesting, dut1 with nesting.
module tb_pic_ctrl;

    localparam logic [15:0] C = 16'h0020;
    localparam logic [15:0] D = 16'h0021;

    logic        clock;
    logic        reset;
    logic [7:0]  irq;
    logic [15:0] port_a;
    logic        port_w;
    logic        port_r;
    logic [7:0]  port_o;

    logic [7:0]  pi0, intn0, pi1, intn1;
    logic        intr0, busy0, intr1, busy1;

    int pass_cnt;
    int total_cnt;

    pic_ctrl #(.NESTED(0)) dut0 (
        .clock(clock), .reset(reset), .irq(irq), .port_a(port_a),
        .port_w(port_w), .port_r(port_r), .port_o(port_o),
        .port_i(pi0), .intr(intr0), .intn(intn0), .isr_busy(busy0)
    );

    pic_ctrl #(.NESTED(1)) dut1 (
        .clock(clock), .reset(reset), .irq(irq), .port_a(port_a),
        .port_w(port_w), .port_r(port_r), .port_o(port_o),
        .port_i(pi1), .intr(intr1), .intn(intn1), .isr_busy(busy1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  irq;
        logic        w;
        logic        r;
        logic [15:0] a;
        logic [7:0]  d;
        logic        e_intr;
        logic [7:0]  e_intn;
        logic [7:0]  e_pi;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [7:0] i, input logic w, input logic r,
                       input logic [15:0] a, input logic [7:0] d,
                       input logic ei, input logic [7:0] en,
                       input logic [7:0] ep, input logic eb);
        vec_t v;
        v.irq = i; v.w = w; v.r = r; v.a = a; v.d = d;
        v.e_intr = ei; v.e_intn = en; v.e_pi = ep; v.e_busy = eb;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Drive one cycle of inputs, clock it, return on the following falling edge
    task automatic cyc(input logic [7:0] i, input logic w, input logic r,
                       input logic [15:0] a, input logic [7:0] d);
        irq = i; port_w = w; port_r = r; port_a = a; port_o = d;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        irq = 8'h00; port_w = 1'b0; port_r = 1'b0; port_a = 16'h0000; port_o = 8'h00;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    int   toggles;
    logic prev;

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset  = 1'b1;
        irq    = 8'h00;
        port_w = 1'b0;
        port_r = 1'b0;
        port_a = 16'h0000;
        port_o = 8'h00;

        // ---- vector table (dut0, no nesting) ----
        // basic delivery of line 1, ISR/IRR readback, EOI
        add(8'h02, 0, 0, C, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
        add(8'h00, 0, 0, C, 8'h00, 1'b1, 8'h09, 8'h00, 1'b1);
        add(8'h00, 1, 0, C, 8'h0B, 1'b1, 8'h09, 8'h00, 1'b1);
        add(8'h00, 0, 1, C, 8'h00, 1'b1, 8'h09, 8'h02, 1'b1);
        add(8'h00, 1, 0, C, 8'h0A, 1'b1, 8'h09, 8'h02, 1'b1);
        add(8'h00, 0, 1, C, 8'h00, 1'b1, 8'h09, 8'h00, 1'b1);
        add(8'h00, 0, 0, C, 8'h00, 1'b1, 8'h09, 8'h00, 1'b1);
        add(8'h00, 1, 0, C, 8'h20, 1'b1, 8'h09, 8'h00, 1'b0);
        // lines 0 and 2 together: 0 first, 2 waits for EOI
        add(8'h05, 0, 0, C, 8'h00, 1'b1, 8'h09, 8'h00, 1'b0);
        add(8'h00, 0, 0, C, 8'h00, 1'b0, 8'h08, 8'h00, 1'b1);
        add(8'h00, 0, 1, C, 8'h00, 1'b0, 8'h08, 8'h04, 1'b1);
        add(8'h00, 0, 0, C, 8'h00, 1'b0, 8'h08, 8'h04, 1'b1);
        add(8'h00, 1, 0, C, 8'h20, 1'b0, 8'h08, 8'h04, 1'b0);
        add(8'h00, 0, 0, C, 8'h00, 1'b1, 8'h0A, 8'h04, 1'b1);
        add(8'h00, 1, 0, C, 8'h0B, 1'b1, 8'h0A, 8'h04, 1'b1);
        add(8'h00, 0, 1, C, 8'h00, 1'b1, 8'h0A, 8'h04, 1'b1);
        add(8'h00, 1, 0, C, 8'h20, 1'b1, 8'h0A, 8'h04, 1'b0);
        add(8'h00, 0, 1, C, 8'h00, 1'b1, 8'h0A, 8'h00, 1'b0);
        // masking: request held in IRR until unmasked
        add(8'h00, 1, 0, D, 8'h06, 1'b1, 8'h0A, 8'h00, 1'b0);
        add(8'h02, 0, 0, C, 8'h00, 1'b1, 8'h0A, 8'h00, 1'b0);
        add(8'h00, 0, 0, C, 8'h00, 1'b1, 8'h0A, 8'h00, 1'b0);
        add(8'h00, 1, 0, C, 8'h0A, 1'b1, 8'h0A, 8'h00, 1'b0);
        add(8'h00, 0, 1, C, 8'h00, 1'b1, 8'h0A, 8'h02, 1'b0);
        add(8'h00, 0, 1, D, 8'h00, 1'b1, 8'h0A, 8'h06, 1'b0);
        add(8'h00, 1, 0, D, 8'h00, 1'b1, 8'h0A, 8'h06, 1'b0);
        add(8'h00, 0, 0, C, 8'h00, 1'b0, 8'h09, 8'h06, 1'b1);
        // unmapped read holds port_i; write+read same cycle returns old value
        add(8'h00, 0, 1, 16'h0030, 8'h00, 1'b0, 8'h09, 8'h06, 1'b1);
        add(8'h00, 1, 0, C, 8'h20, 1'b0, 8'h09, 8'h06, 1'b0);
        add(8'h00, 1, 1, D, 8'h0F, 1'b0, 8'h09, 8'h00, 1'b0);
        add(8'h00, 0, 1, D, 8'h00, 1'b0, 8'h09, 8'h0F, 1'b0);
        add(8'h00, 1, 0, D, 8'h00, 1'b0, 8'h09, 8'h0F, 1'b0);

        // ---- reset state ----
        repeat (2) @(negedge clock);
        chk("reset intr", {7'd0, intr0}, 8'h00);
        chk("reset intn", intn0, 8'h00);
        chk("reset port_i", pi0, 8'h00);
        chk("reset busy", {7'd0, busy0}, 8'h00);
        reset = 1'b0;

        foreach (vecs[k]) begin
            cyc(vecs[k].irq, vecs[k].w, vecs[k].r, vecs[k].a, vecs[k].d);
            chk($sformatf("v%0d intr", k), {7'd0, intr0}, {7'd0, vecs[k].e_intr});
            chk($sformatf("v%0d intn", k), intn0, vecs[k].e_intn);
            chk($sformatf("v%0d port_i", k), pi0, vecs[k].e_pi);
            chk($sformatf("v%0d busy", k), {7'd0, busy0}, {7'd0, vecs[k].e_busy});
        end

        // ---- nesting (dut1): line 1 preempts line 3, line 5 held ----
        do_reset();
        cyc(8'h08, 0, 0, C, 8'h00);
        cyc(8'h00, 0, 0, C, 8'h00);
        chk("nest first intr", {7'd0, intr1}, 8'h01);
        chk("nest first intn", intn1, 8'h0B);
        cyc(8'h02, 0, 0, C, 8'h00);
        cyc(8'h00, 0, 0, C, 8'h00);
        chk("nest preempt intr", {7'd0, intr1}, 8'h00);
        chk("nest preempt intn", intn1, 8'h09);
        cyc(8'h00, 1, 0, C, 8'h0B);
        cyc(8'h00, 0, 1, C, 8'h00);
        chk("nest isr 0A", pi1, 8'h0A);
        cyc(8'h20, 0, 0, C, 8'h00);
        cyc(8'h00, 0, 0, C, 8'h00);
        cyc(8'h00, 0, 0, C, 8'h00);
        chk("nest line5 held", {7'd0, intr1}, 8'h00);
        cyc(8'h00, 1, 0, C, 8'h61);
        cyc(8'h00, 0, 1, C, 8'h00);
        chk("nest isr after eoi61", pi1, 8'h08);
        cyc(8'h00, 0, 0, C, 8'h00);
        chk("nest line5 still held", {7'd0, intr1}, 8'h00);
        cyc(8'h00, 1, 0, C, 8'h0A);
        cyc(8'h00, 0, 1, C, 8'h00);
        chk("nest irr 20", pi1, 8'h20);

        // ---- held level gives one request; edge during delivery re-arms ----
        do_reset();
        toggles = 0;
        prev    = intr0;
        for (int n = 0; n < 100; n++) begin
            cyc(8'h10, 0, 0, C, 8'h00);
            if (intr0 !== prev) toggles++;
            prev = intr0;
        end
        chk("level one delivery", 8'(toggles), 8'h01);
        chk("level intn", intn0, 8'h0C);
        cyc(8'h00, 0, 0, C, 8'h00);
        cyc(8'h10, 0, 0, C, 8'h00);
        cyc(8'h00, 0, 0, C, 8'h00);
        cyc(8'h00, 1, 0, C, 8'h20);
        chk("eoi no same-cycle dlv", {7'd0, intr0}, 8'h01);
        chk("eoi busy clear", {7'd0, busy0}, 8'h00);
        cyc(8'h10, 0, 0, C, 8'h00);
        chk("edge+dlv intr", {7'd0, intr0}, 8'h00);
        chk("edge+dlv busy", {7'd0, busy0}, 8'h01);
        cyc(8'h00, 0, 1, C, 8'h00);
        chk("edge+dlv irr kept", pi0, 8'h10);
        cyc(8'h00, 1, 0, C, 8'h20);
        cyc(8'h00, 0, 0, C, 8'h00);
        chk("rearmed delivery", {7'd0, intr0}, 8'h01);

        // ---- asynchronous reset with pending and in-service state ----
        do_reset();
        cyc(8'hFF, 0, 0, C, 8'h00);
        cyc(8'h00, 0, 0, C, 8'h00);
        cyc(8'h01, 0, 0, C, 8'h00);
        cyc(8'h00, 0, 0, C, 8'h00);
        cyc(8'h00, 1, 0, D, 8'h55);
        cyc(8'h00, 0, 1, D, 8'h00);
        chk("pre-reset intr", {7'd0, intr0}, 8'h01);
        chk("pre-reset intn", intn0, 8'h08);
        chk("pre-reset port_i", pi0, 8'h55);
        port_r = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async intr", {7'd0, intr0}, 8'h00);
        chk("async intn", intn0, 8'h00);
        chk("async port_i", pi0, 8'h00);
        chk("async busy", {7'd0, busy0}, 8'h00);
        @(negedge clock);
        reset = 1'b0;
        cyc(8'h00, 0, 1, D, 8'h00);
        chk("post-reset imr", pi0, 8'h00);
        cyc(8'h00, 1, 0, D, 8'h0C);
        cyc(8'h00, 0, 1, D, 8'h00);
        chk("post-reset imr write", pi0, 8'h0C);
        cyc(8'h00, 0, 1, C, 8'h00);
        chk("post-reset irr", pi0, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
